// File: rtl/riscv_mem_arbiter.sv
// Fetch/LSU arbiter for a single-port word memory: grants, byte lanes,
// load extension and misaligned/illegal access rejection.
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req_i,
    input  logic [DATA_WIDTH-1:0]   if_addr_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [2:0]              d_funct3_i,
    input  logic [DATA_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_err_o,
    output logic                    mem_en_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

    state_t                  r_state, w_next;
    logic [1:0]              r_streak;
    logic                    r_own_d, r_we;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_addr, r_wdata;

    logic                    w_idle, w_if_gnt, w_d_gnt;
    logic                    w_f3_ok, w_align_ok;
    logic [DATA_WIDTH-1:0]   w_shift, w_load;

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    assign w_idle   = (r_state == S_IDLE) && rst_n;
    assign w_d_gnt  = w_idle && d_req_i && !(if_req_i && (r_streak == 2'd2));
    assign w_if_gnt = w_idle && if_req_i && !w_d_gnt;
    assign if_gnt_o = w_if_gnt;
    assign d_gnt_o  = w_d_gnt;

    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b1;
        case (d_funct3_i)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = !d_we_i;
            default:                w_f3_ok = 1'b0;
        endcase
        case (d_funct3_i[1:0])
            2'b01:   w_align_ok = !d_addr_i[0];
            2'b10:   w_align_ok = (d_addr_i[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_streak <= '0;
            r_own_d  <= 1'b0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_if_gnt) begin
                r_streak <= '0;
                r_own_d  <= 1'b0;
                r_we     <= 1'b0;
                r_funct3 <= 3'b010;
                r_addr   <= if_addr_i;
                r_wdata  <= '0;
            end else if (w_d_gnt) begin
                if (if_req_i && (r_streak != 2'd2))
                    r_streak <= r_streak + 2'd1;
                r_own_d  <= 1'b1;
                r_we     <= d_we_i;
                r_funct3 <= d_funct3_i;
                r_addr   <= d_addr_i;
                r_wdata  <= d_wdata_i;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_if_gnt)
                    w_next = S_ACCESS;
                else if (w_d_gnt)
                    w_next = (w_f3_ok && w_align_ok) ? S_ACCESS : S_ERR;
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Byte/half lane selected by shifting the word down by the byte offset.
    assign w_shift = mem_rdata_i >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = mem_rdata_i;
        endcase
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        d_err_o     = 1'b0;
        case (r_state)
            S_ACCESS: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {r_addr[DATA_WIDTH-1:2], 2'b00};
                mem_be_o   = '1;
                if (r_own_d && r_we) begin
                    mem_we_o = 1'b1;
                    case (r_funct3[1:0])
                        2'b00: begin
                            mem_be_o    = 4'b0001 << r_addr[1:0];
                            mem_wdata_o = {4{r_wdata[7:0]}};
                        end
                        2'b01: begin
                            mem_be_o    = r_addr[1] ? 4'b1100 : 4'b0011;
                            mem_wdata_o = {2{r_wdata[15:0]}};
                        end
                        default: mem_wdata_o = r_wdata;
                    endcase
                end
            end
            S_RESP: begin
                if (r_own_d) begin
                    d_rvalid_o = 1'b1;
                    if (!r_we)
                        d_rdata_o = w_load;
                end else begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                end
            end
            S_ERR: begin
                d_rvalid_o = 1'b1;
                d_err_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: cycle-scheduled behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [2:0]  d_funct3_i = '0;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_funct3_i(d_funct3_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    int n_chk = 0, n_err = 0, cyc = 0;

    // Model: one outstanding transaction, scheduled by absolute cycle numbers.
    int          m_acc = -1, m_resp = -1, m_free = 0, m_streak = 0;
    logic        m_own_d = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [2:0]  m_f3 = '0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    // Snapshots of DUT outputs for the three cycles of a directed transaction.
    logic        s_ig[3], s_dg[3], s_en[3], s_we[3], s_irv[3], s_drv[3], s_err[3];
    logic [31:0] s_be[3], s_ma[3], s_wd[3], s_ird[3], s_drd[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit ok_code;
        int sz;
        ok_code = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f3[1:0];
        return ok_code && ((int'(a[1:0]) % sz) == 0);
    endfunction

    function automatic void store_lanes(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d, output logic [3:0] be,
                                        output logic [31:0] wd);
        int nb, off;
        nb = 1 << f3[1:0];
        off = int'(a[1:0]);
        be = '0;
        wd = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[i] = 1'b1;
            wd[8*i +: 8] = d[8*(i % nb) +: 8];
        end
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
        int nb, off;
        logic [31:0] v, mask;
        nb = 1 << f3[1:0];
        off = int'(a[1:0]);
        v = w >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v = v & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drv(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [2:0] f3, input logic [31:0] daddr,
                       input logic [31:0] wd, input logic [31:0] mrd);
        if_req_i = ireq; if_addr_i = iaddr;
        d_req_i = dreq; d_we_i = dwe; d_funct3_i = f3; d_addr_i = daddr; d_wdata_i = wd;
        mem_rdata_i = mrd;
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic chk_cycle();
        logic        e_ig, e_dg, e_en, e_mwe, e_irv, e_drv, e_err;
        logic [3:0]  e_be;
        logic [31:0] e_ma, e_wd, e_ird, e_drd;
        #1;
        e_ig = 0; e_dg = 0; e_en = 0; e_mwe = 0; e_irv = 0; e_drv = 0; e_err = 0;
        e_be = '0; e_ma = '0; e_wd = '0; e_ird = '0; e_drd = '0;
        if (cyc >= m_free) begin
            if (d_req_i && (!if_req_i || m_streak != 2)) e_dg = 1;
            else if (if_req_i) e_ig = 1;
        end
        if (cyc == m_acc) begin
            e_en = 1;
            e_ma = {m_addr[31:2], 2'b00};
            e_be = 4'hF;
            if (m_own_d && m_we) begin
                e_mwe = 1;
                store_lanes(m_f3, m_addr, m_wdata, e_be, e_wd);
            end
        end
        if (cyc == m_resp) begin
            if (m_own_d) begin
                e_drv = 1;
                e_err = m_err;
                e_drd = (m_err || m_we) ? 32'h0 : load_ext(mem_rdata_i, m_addr, m_f3);
            end else begin
                e_irv = 1;
                e_ird = mem_rdata_i;
            end
        end
        chk("if_gnt", 32'(if_gnt_o), 32'(e_ig));
        chk("d_gnt", 32'(d_gnt_o), 32'(e_dg));
        chk("mem_en", 32'(mem_en_o), 32'(e_en));
        chk("mem_we", 32'(mem_we_o), 32'(e_mwe));
        chk("mem_be", 32'(mem_be_o), 32'(e_be));
        chk("mem_addr", mem_addr_o, e_ma);
        chk("mem_wdata", mem_wdata_o, e_wd);
        chk("if_rvalid", 32'(if_rvalid_o), 32'(e_irv));
        chk("if_rdata", if_rdata_o, e_ird);
        chk("d_rvalid", 32'(d_rvalid_o), 32'(e_drv));
        chk("d_err", 32'(d_err_o), 32'(e_err));
        chk("d_rdata", d_rdata_o, e_drd);
        if (e_ig) begin
            m_streak = 0; m_own_d = 0; m_we = 0; m_err = 0; m_f3 = 3'b010;
            m_addr = if_addr_i; m_wdata = '0;
            m_acc = cyc + 1; m_resp = cyc + 2; m_free = cyc + 3;
        end else if (e_dg) begin
            if (if_req_i && m_streak < 2) m_streak++;
            m_own_d = 1; m_we = d_we_i; m_f3 = d_funct3_i;
            m_addr = d_addr_i; m_wdata = d_wdata_i;
            m_err = !legal(d_we_i, d_funct3_i, d_addr_i);
            if (m_err) begin
                m_acc = -1; m_resp = cyc + 1; m_free = cyc + 2;
            end else begin
                m_acc = cyc + 1; m_resp = cyc + 2; m_free = cyc + 3;
            end
        end
    endtask

    task automatic snap(input int k);
        s_ig[k] = if_gnt_o; s_dg[k] = d_gnt_o; s_en[k] = mem_en_o; s_we[k] = mem_we_o;
        s_irv[k] = if_rvalid_o; s_drv[k] = d_rvalid_o; s_err[k] = d_err_o;
        s_be[k] = 32'(mem_be_o); s_ma[k] = mem_addr_o; s_wd[k] = mem_wdata_o;
        s_ird[k] = if_rdata_o; s_drd[k] = d_rdata_o;
    endtask

    task automatic txn(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                       input logic dwe, input logic [2:0] f3, input logic [31:0] daddr,
                       input logic [31:0] wd, input logic [31:0] mrd);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) drv(ireq, iaddr, dreq, dwe, f3, daddr, wd, mrd);
            else        drv(0, '0, 0, 0, '0, '0, '0, mrd);
            chk_cycle();
            snap(k);
            adv();
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(0, '0, 0, 0, '0, '0, '0, $urandom);
            chk_cycle();
            adv();
        end
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_if_gnt"}, 32'(if_gnt_o), 32'h0);
        chk({nm, "_d_gnt"}, 32'(d_gnt_o), 32'h0);
        chk({nm, "_mem_en"}, 32'(mem_en_o), 32'h0);
        chk({nm, "_mem_we"}, 32'(mem_we_o), 32'h0);
        chk({nm, "_mem_be"}, 32'(mem_be_o), 32'h0);
        chk({nm, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({nm, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk({nm, "_if_rvalid"}, 32'(if_rvalid_o), 32'h0);
        chk({nm, "_if_rdata"}, if_rdata_o, 32'h0);
        chk({nm, "_d_rvalid"}, 32'(d_rvalid_o), 32'h0);
        chk({nm, "_d_err"}, 32'(d_err_o), 32'h0);
        chk({nm, "_d_rdata"}, d_rdata_o, 32'h0);
    endtask

    initial begin
        logic [5:0] seq;
        int         ngr;
        logic [31:0] ra;

        drv(1, 32'h40, 1, 0, 3'b010, 32'h80, '0, 32'hFFFF_FFFF);
        #2;
        all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Both ports requesting back to back: data twice, then fetch.
        seq = '0;
        ngr = 0;
        for (int k = 0; k < 18; k++) begin
            drv(1, 32'h10, 1, 0, 3'b010, 32'h20, '0, $urandom);
            chk_cycle();
            if (if_gnt_o || d_gnt_o) begin
                seq = {seq[4:0], d_gnt_o};
                ngr++;
            end
            adv();
        end
        chk("grant_order", 32'(seq), 32'(6'b110110));
        chk("grant_count", 32'(ngr), 32'd6);
        idle(1);

        txn(1, 32'h104, 0, 0, '0, '0, '0, 32'hDEAD_BEEF);
        chk("fetch_gnt", 32'(s_ig[0]), 32'h1);
        chk("fetch_en", 32'(s_en[1]), 32'h1);
        chk("fetch_addr", s_ma[1], 32'h104);
        chk("fetch_early_rvalid", 32'(s_irv[1]), 32'h0);
        chk("fetch_rvalid", 32'(s_irv[2]), 32'h1);
        chk("fetch_rdata", s_ird[2], 32'hDEAD_BEEF);

        txn(0, '0, 1, 0, 3'b000, 32'h203, '0, 32'h80FF_0000);
        chk("lb_be", s_be[1], 32'hF);
        chk("lb_addr", s_ma[1], 32'h200);
        chk("lb_rdata", s_drd[2], 32'hFFFF_FF80);
        txn(0, '0, 1, 0, 3'b100, 32'h203, '0, 32'h80FF_0000);
        chk("lbu_rdata", s_drd[2], 32'h0000_0080);

        txn(0, '0, 1, 1, 3'b001, 32'h302, 32'hABCD_1234, 32'h5555_AAAA);
        chk("sh_be", s_be[1], 32'hC);
        chk("sh_wdata", s_wd[1], 32'h1234_1234);
        chk("sh_addr", s_ma[1], 32'h300);
        chk("sh_we", 32'(s_we[1]), 32'h1);
        chk("sh_rvalid", 32'(s_drv[2]), 32'h1);
        chk("sh_rdata", s_drd[2], 32'h0);

        txn(0, '0, 1, 0, 3'b010, 32'h401, '0, 32'h1111_2222);
        chk("lw_mis_en", 32'(s_en[1]), 32'h0);
        chk("lw_mis_rvalid", 32'(s_drv[1]), 32'h1);
        chk("lw_mis_err", 32'(s_err[1]), 32'h1);
        chk("lw_mis_rdata", s_drd[1], 32'h0);
        txn(0, '0, 1, 1, 3'b100, 32'h400, 32'h77, 32'h3333_4444);
        chk("st_bad_en", 32'(s_en[1]), 32'h0);
        chk("st_bad_err", 32'(s_err[1]), 32'h1);

        // Reset pulled asynchronously in the middle of an ACCESS cycle.
        drv(1, 32'h500, 0, 0, '0, '0, '0, 32'h9999_0000);
        chk_cycle();
        adv();
        drv(0, '0, 0, 0, '0, '0, '0, 32'h9999_0000);
        chk_cycle();
        chk("rst_pre_en", 32'(mem_en_o), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        all_zero("rst_async");
        m_acc = -1; m_resp = -1; m_free = 0; m_streak = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drv(1, 32'h600, 1, 0, 3'b010, 32'h700, '0, 32'h9999_0000);
        #1;
        all_zero("rst_hold");
        drv(0, '0, 0, 0, '0, '0, '0, 32'h9999_0000);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        txn(1, 32'h604, 0, 0, '0, '0, '0, 32'hCAFE_F00D);
        chk("post_rst_rvalid", 32'(s_irv[2]), 32'h1);
        chk("post_rst_rdata", s_ird[2], 32'hCAFE_F00D);

        for (int k = 0; k < 600; k++) begin
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            drv(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, $urandom);
            chk_cycle();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Arbitrates a single-port, word-wide data memory between the instruction-fetch port and the load/store (data) port of the RV32I core. Sequences each access through a small state machine, generates byte enables for SB/SH/SW, extends LB/LH/LBU/LHU results, and rejects misaligned or illegal-size data accesses without touching memory. Sits between the core's fetch/LSU stages and the memory macro.

## Interface
- DATA_WIDTH, 32, data and address width (RV32I); byte-enable width is DATA_WIDTH/8
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request
- if_addr_i  in  32  fetch byte address; bits [1:0] ignored
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid, 1-cycle pulse
- if_rdata_o  out  32  fetched word, valid with if_rvalid_o
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_funct3_i  in  3  access size/sign, RV32I funct3 encoding
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data, right-aligned (byte/half in low bits)
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid (loads and stores), 1-cycle pulse
- d_rdata_o  out  32  extended load result; 0 for stores and errors
- d_err_o  out  1  misaligned/illegal access, valid with d_rvalid_o
- mem_en_o  out  1  memory access strobe
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word address (byte address with [1:0] = 0)
- mem_wdata_o  out  32  write data, lane-shifted
- mem_rdata_i  in  32  read word, valid the cycle after mem_en_o

## Operation
- States: IDLE, ACCESS, RESP, ERR. Reset -> IDLE.
- Grants are combinational and asserted only in IDLE; a request is accepted when req && gnt at a rising edge. At most one gnt per cycle.
- Arbitration in IDLE: only one requester -> grant it. Both -> grant data unless streak == 2, then grant fetch.
- streak (2-bit, saturating at 2): clears on fetch grant; increments on data grant while if_req_i high; unchanged otherwise.
- Data check at acceptance: legal loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores 000 SB, 001 SH, 010 SW. Half needs addr[0] = 0, word needs addr[1:0] = 00. Illegal funct3 or misalignment -> ERR, else ACCESS. Fetch -> always ACCESS.
- Request fields are captured into registers on acceptance; inputs may change afterwards.
- ACCESS (1 cycle): mem_en_o = 1, mem_addr_o = {addr[31:2],2'b00}. Store: mem_we_o = 1, SB be = 1<<addr[1:0] with byte replicated to all lanes, SH be = 0011 or 1100 with half replicated, SW be = 1111. Load/fetch: mem_we_o = 0, be = 1111. -> RESP.
- RESP (1 cycle): rvalid to the owner. Load: select byte/half by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), LW passes through. Fetch: mem_rdata_i unchanged. Store: rvalid with rdata = 0. -> IDLE.
- ERR (1 cycle): d_rvalid_o = 1, d_err_o = 1, d_rdata_o = 0, no memory strobe. -> IDLE.
- All mem_* and response outputs are 0 whenever not driven by the above.

## Timing
- Reset values: all outputs 0; state IDLE; streak 0; captured registers 0.
- Accept at edge N -> ACCESS during cycle N+1 -> rvalid during cycle N+2. Error: rvalid + err during cycle N+1.
- Throughput: one access per 3 cycles (2 for errors). No gnt in ACCESS/RESP/ERR.
- A requester holding req through RESP may be granted in the next IDLE cycle (N+3).
- Reset asserted mid-access: immediate return to IDLE, outstanding response dropped, no further mem_en_o.

## Test plan
- Fetch only: if_req at 0x104, mem returns 0xDEADBEEF -> mem_en with addr 0x104 at N+1, if_rvalid with 0xDEADBEEF at N+2.
- LB at 0x203 with mem word 0x80FF_0000 -> be 1111, d_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH of 0x1234 at 0x302 -> mem_be 1100, mem_wdata 0x12341234, mem_addr 0x300, d_rvalid with rdata 0.
- LW at 0x401 and store funct3 100 -> no mem_en, d_rvalid + d_err at N+1, rdata 0.
- Both ports requesting continuously -> grant order D, D, F, D, D, F; streak clears on each F.
- rst_n dropped in ACCESS -> all outputs 0 asynchronously, no rvalid after release, next request served normally.
